bus_mailbox: RTL and testbench

- Memory-mapped responder on the CPU data bus (CS/WE/ADDR/Data_BUS_WRITE in, Data_BUS_READ out).
- Provides two FIFOs:
  - TX: CPU writes, external consumer drains over valid/ready.
  - RX: external producer fills over valid/ready, CPU reads.
- Base-address decode is external; this block responds only when CS=1 and decodes ADDR[3:2].

---
 rtl/bus_mailbox_pkg.sv | 28 ++
 rtl/bus_mailbox_sync_fifo.sv | 55 +++++
 rtl/bus_mailbox.sv | 158 +++++++++++++++
 tb/tb_bus_mailbox.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mailbox_pkg.sv
// Shared constants for bus_mailbox: register offsets (ADDR[3:2]),
// STATUS bit positions and CONTROL bit positions.
package mailbox_pkg;

  // Register offsets decoded from ADDR[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_FULL     = 2;
  localparam int ST_RX_EMPTY    = 3;
  localparam int ST_TX_OVERFLOW = 4;
  localparam int ST_RX_UNDERFLOW = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  // CONTROL bit positions; [1:0] are self-clearing flush strobes
  localparam int CTL_TX_FLUSH = 0;
  localparam int CTL_RX_FLUSH = 1;
  localparam int CTL_RX_IE    = 2;
  localparam int CTL_TX_IE    = 3;
  localparam int CTL_ERR_IE   = 4;

endpackage

// File: rtl/bus_mailbox_sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush strobes.
// Pushes into a full FIFO and pops from an empty one are ignored.
// Flush wins over push/pop in the same cycle. No fall-through: a pushed
// word reaches the head on the following cycle at the earliest.
// head reads 0 while the FIFO is empty.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        pushData,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic              doPush;
  logic              doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = empty ? '0 : mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush and reset zero everything
  always_ff @(posedge CLK) begin
    if (Reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage write; contents need no reset because head is gated by empty
  always_ff @(posedge CLK) begin
    if (doPush && !flush && !Reset) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bus_mailbox.sv
// bus_mailbox: CPU-bus mapped TX/RX mailbox built from two sync_fifo
// instances. ADDR[3:2] selects TXDATA, RXDATA, STATUS or CONTROL.
// Optional build macro MAILBOX_IRQ_EN adds the irq output and the
// read/write interrupt-enable bits in CONTROL.
//
// Stream handshakes: a word moves on a rising edge exactly when valid
// and ready are both 1 in the preceding cycle. tx_valid = TX not empty,
// rx_ready = RX not full; neither depends combinationally on the
// partner's valid/ready, and a producer must hold rx_data/rx_valid until
// the transfer happens.
module bus_mailbox
  import mailbox_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              CS,
  input  logic              WE,
  input  logic [31:0]       ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef MAILBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        regSel;
  logic              isWrite, isRead;
  logic              txPush, txPop, txFlush, txFull, txEmpty;
  logic              rxPush, rxPop, rxFlush, rxFull, rxEmpty;
  logic              txOverflowSet, rxUnderflowSet;
  logic              txOverflow, rxUnderflow;
  logic [CW-1:0]     txCount, rxCount;
  logic [DATA_W-1:0] rxHead;
  logic [DATA_W-1:0] statusWord;
  logic [DATA_W-1:0] readMux;
  logic              unusedAddrBits;

  assign unusedAddrBits = &{1'b0, ADDR[31:4], ADDR[1:0]};

  assign regSel  = ADDR[3:2];
  assign isWrite = CS & WE;
  assign isRead  = CS & ~WE;

  // TX side: a write to a full FIFO is dropped even if a pop happens too
  assign txPush        = isWrite & (regSel == REG_TXDATA) & ~txFull;
  assign txOverflowSet = isWrite & (regSel == REG_TXDATA) & txFull;
  assign txFlush       = isWrite & (regSel == REG_CONTROL) & Data_BUS_WRITE[CTL_TX_FLUSH];
  assign txPop         = ~txEmpty & tx_ready;
  assign tx_valid      = ~txEmpty;

  // RX side: reading an empty FIFO flags underflow instead of popping
  assign rxPop          = isRead & (regSel == REG_RXDATA) & ~rxEmpty;
  assign rxUnderflowSet = isRead & (regSel == REG_RXDATA) & rxEmpty;
  assign rxFlush        = isWrite & (regSel == REG_CONTROL) & Data_BUS_WRITE[CTL_RX_FLUSH];
  assign rxPush         = rx_valid & ~rxFull;
  assign rx_ready       = ~rxFull;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) txFifo (
    .CLK(CLK), .Reset(Reset), .push(txPush), .pop(txPop), .flush(txFlush),
    .pushData(Data_BUS_WRITE), .head(tx_data), .full(txFull), .empty(txEmpty),
    .count(txCount)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) rxFifo (
    .CLK(CLK), .Reset(Reset), .push(rxPush), .pop(rxPop), .flush(rxFlush),
    .pushData(rx_data), .head(rxHead), .full(rxFull), .empty(rxEmpty),
    .count(rxCount)
  );

`ifdef MAILBOX_IRQ_EN
  logic rxIe, txIe, errIe;

  // Interrupt enables load on any CONTROL write; irq lags state by one edge
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rxIe  <= 1'b0;
      txIe  <= 1'b0;
      errIe <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (isWrite && regSel == REG_CONTROL) begin
        rxIe  <= Data_BUS_WRITE[CTL_RX_IE];
        txIe  <= Data_BUS_WRITE[CTL_TX_IE];
        errIe <= Data_BUS_WRITE[CTL_ERR_IE];
      end
      irq <= (rxIe & ~rxEmpty) | (txIe & txEmpty) | (errIe & (txOverflow | rxUnderflow));
    end
  end
`endif

  // Sticky error flags: set by the faulting access, cleared by W1C to STATUS
  always_ff @(posedge CLK) begin
    if (Reset) begin
      txOverflow  <= 1'b0;
      rxUnderflow <= 1'b0;
    end else begin
      if (txOverflowSet)
        txOverflow <= 1'b1;
      else if (isWrite && regSel == REG_STATUS && Data_BUS_WRITE[ST_TX_OVERFLOW])
        txOverflow <= 1'b0;
      if (rxUnderflowSet)
        rxUnderflow <= 1'b1;
      else if (isWrite && regSel == REG_STATUS && Data_BUS_WRITE[ST_RX_UNDERFLOW])
        rxUnderflow <= 1'b0;
    end
  end

  // STATUS word built from the pre-access state of this cycle
  always_comb begin
    statusWord = '0;
    statusWord[ST_TX_FULL]      = txFull;
    statusWord[ST_TX_EMPTY]     = txEmpty;
    statusWord[ST_RX_FULL]      = rxFull;
    statusWord[ST_RX_EMPTY]     = rxEmpty;
    statusWord[ST_TX_OVERFLOW]  = txOverflow;
    statusWord[ST_RX_UNDERFLOW] = rxUnderflow;
    statusWord[ST_TX_COUNT_LSB +: 8] = 8'(txCount);
    statusWord[ST_RX_COUNT_LSB +: 8] = 8'(rxCount);
  end

  // Read data selection for the addressed register
  always_comb begin
    readMux = '0;
    case (regSel)
      REG_RXDATA: readMux = rxEmpty ? '0 : rxHead;
      REG_STATUS: readMux = statusWord;
`ifdef MAILBOX_IRQ_EN
      REG_CONTROL: begin
        readMux[CTL_RX_IE]  = rxIe;
        readMux[CTL_TX_IE]  = txIe;
        readMux[CTL_ERR_IE] = errIe;
      end
`endif
      default: readMux = '0;
    endcase
  end

  // Registered read port: loads only on read cycles, holds otherwise
  always_ff @(posedge CLK) begin
    if (Reset)
      Data_BUS_READ <= '0;
    else if (isRead)
      Data_BUS_READ <= readMux;
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: a queue-based model of the
// mailbox checked every cycle, plus directed scenarios with literal
// expected values.
module tb_bus_mailbox;

  localparam int DEPTH = 8;

  logic        clk;
  logic        Reset;
  logic        CS, WE;
  logic [31:0] ADDR, wdata, Data_BUS_READ;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef MAILBOX_IRQ_EN
  logic        irq;
`endif

  int nChecks = 0;
  int nFail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_mailbox #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK(clk), .Reset(Reset), .CS(CS), .WE(WE), .ADDR(ADDR),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(Data_BUS_READ),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef MAILBOX_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  logic [31:0] expRd;
  bit          mOvf, mUnf, modelReady;
  bit          mRxIe, mTxIe, mErrIe, expIrq;
  int          txN, rxN;
  bit          doTxPop, doRxPush, doTxPush, doRxPop, flTx, flRx;
  logic [31:0] stNow;

  function automatic logic [31:0] statusOf(int tn, int rn, bit ovf, bit unf);
    logic [7:0] tc, rc;
    tc = 8'(tn);
    rc = 8'(rn);
    return {8'h00, rc, tc, 2'b00, unf, ovf, rn == 0, rn == DEPTH, tn == 0, tn == DEPTH};
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      txQ.delete();
      rxQ.delete();
      expRd = 0; mOvf = 0; mUnf = 0;
      mRxIe = 0; mTxIe = 0; mErrIe = 0; expIrq = 0;
      modelReady = 1;
    end else if (modelReady) begin
      txN = txQ.size();
      rxN = rxQ.size();
      expIrq = (mRxIe && rxN != 0) || (mTxIe && txN == 0) || (mErrIe && (mOvf || mUnf));
      stNow = statusOf(txN, rxN, mOvf, mUnf);
      doTxPop = (txN > 0) && tx_ready;
      doRxPush = rx_valid && (rxN < DEPTH);
      doTxPush = 0; doRxPop = 0; flTx = 0; flRx = 0;
      if (CS && WE) begin
        case (ADDR[3:2])
          2'd0: if (txN == DEPTH) mOvf = 1; else doTxPush = 1;
          2'd2: begin
            if (wdata[4]) mOvf = 0;
            if (wdata[5]) mUnf = 0;
          end
          2'd3: begin
            flTx = wdata[0];
            flRx = wdata[1];
`ifdef MAILBOX_IRQ_EN
            mRxIe = wdata[2]; mTxIe = wdata[3]; mErrIe = wdata[4];
`endif
          end
          default: ;
        endcase
      end else if (CS) begin
        case (ADDR[3:2])
          2'd1: if (rxN == 0) begin expRd = 0; mUnf = 1; end
                else begin expRd = rxQ[0]; doRxPop = 1; end
          2'd2: expRd = stNow;
`ifdef MAILBOX_IRQ_EN
          2'd3: expRd = {27'd0, mErrIe, mTxIe, mRxIe, 2'b00};
`endif
          default: expRd = 0;
        endcase
      end
      if (flTx) txQ.delete();
      else begin
        if (doTxPop) void'(txQ.pop_front());
        if (doTxPush) txQ.push_back(wdata);
      end
      if (flRx) rxQ.delete();
      else begin
        if (doRxPop) void'(rxQ.pop_front());
        if (doRxPush) rxQ.push_back(rx_data);
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (modelReady) begin
      checkEq("tx_valid", {31'd0, tx_valid}, {31'd0, txQ.size() != 0});
      checkEq("tx_data", tx_data, (txQ.size() != 0) ? txQ[0] : 32'd0);
      checkEq("rx_ready", {31'd0, rx_ready}, {31'd0, rxQ.size() < DEPTH});
      checkEq("Data_BUS_READ", Data_BUS_READ, expRd);
`ifdef MAILBOX_IRQ_EN
      checkEq("irq", {31'd0, irq}, {31'd0, expIrq});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    CS = 1; WE = 1; ADDR = a; wdata = d;
    @(posedge clk); #1;
    CS = 0; WE = 0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    CS = 1; WE = 0; ADDR = a;
    @(posedge clk); #1;
    CS = 0;
    d = Data_BUS_READ;
  endtask

  task automatic rxPushWord(input logic [31:0] d);
    rx_valid = 1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] rd;
  logic [31:0] seq3 [3];

  initial begin
    modelReady = 0;
    Reset = 1; CS = 0; WE = 0; ADDR = 0; wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    repeat (2) @(posedge clk);
    #1 Reset = 0;

    checkEq("reset_rdata", Data_BUS_READ, 32'h0);
    checkEq("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkEq("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
    busRead(32'h8, rd);
    checkEq("status_after_reset", rd, 32'h0000_000A);

    // Three TX words, then drain
    busWrite(32'h0, 32'h11);
    busWrite(32'h0, 32'h22);
    busWrite(32'h0, 32'h33);
    checkEq("tx_head_first", tx_data, 32'h11);
    busRead(32'h8, rd);
    checkEq("status_tx3", rd, 32'h0000_0308);
    seq3[0] = 32'h11; seq3[1] = 32'h22; seq3[2] = 32'h33;
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checkEq("tx_drain_seq", tx_data, seq3[i]);
      @(posedge clk); #1;
    end
    tx_ready = 0;
    checkEq("tx_drained_valid", {31'd0, tx_valid}, 32'd0);

    // TX overflow
    for (int i = 0; i <= DEPTH; i++) busWrite(32'h0, 32'h100 + i);
    busRead(32'h8, rd);
    checkEq("status_tx_overflow", rd, 32'h0000_0819);
    busWrite(32'h8, 32'h10);
    busRead(32'h8, rd);
    checkEq("status_ovf_cleared", rd, 32'h0000_0809);
    tx_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checkEq("tx_full_drain", tx_data, 32'h100 + i);
      @(posedge clk); #1;
    end
    tx_ready = 0;
    checkEq("tx_dropped_word_absent", {31'd0, tx_valid}, 32'd0);

    // RX fill to full, producer waits, then read out plus underflow
    for (int i = 0; i < DEPTH; i++) rxPushWord(32'hA0 + i);
    checkEq("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    rxPushWord(32'hA8);
    for (int i = 0; i < DEPTH; i++) begin
      busRead(32'h4, rd);
      checkEq("rx_read_seq", rd, 32'hA0 + i);
    end
    busRead(32'h4, rd);
    checkEq("rx_read_empty", rd, 32'h0);
    busRead(32'h8, rd);
    checkEq("status_rx_underflow", rd, 32'h0000_002A);
    busWrite(32'h8, 32'h20);

    // Simultaneous pop and push on a 4-entry RX
    for (int i = 0; i < 4; i++) rxPushWord(32'hB0 + i);
    CS = 1; WE = 0; ADDR = 32'h4; rx_valid = 1; rx_data = 32'hB4;
    @(posedge clk); #1;
    CS = 0; rx_valid = 0;
    checkEq("rx_simul_data", Data_BUS_READ, 32'hB0);
    busRead(32'h8, rd);
    checkEq("status_rx_count4", rd, 32'h0004_0002);
    for (int i = 1; i < 5; i++) begin
      busRead(32'h4, rd);
      checkEq("rx_simul_order", rd, 32'hB0 + i);
    end

    // TX flush racing a consumer pop
    for (int i = 0; i < 5; i++) busWrite(32'h0, 32'hC0 + i);
    CS = 1; WE = 1; ADDR = 32'hC; wdata = 32'h1; tx_ready = 1;
    @(posedge clk); #1;
    CS = 0; WE = 0; tx_ready = 0;
    checkEq("flush_tx_valid", {31'd0, tx_valid}, 32'd0);
    busRead(32'h8, rd);
    checkEq("status_after_flush", rd, 32'h0000_000A);

`ifdef MAILBOX_IRQ_EN
    busWrite(32'hC, 32'h4);
    busRead(32'hC, rd);
    checkEq("control_readback", rd, 32'h4);
    rxPushWord(32'hD0);
    checkEq("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    checkEq("irq_rx_set", {31'd0, irq}, 32'd1);
    busRead(32'h4, rd);
    checkEq("irq_pop_data", rd, 32'hD0);
    @(posedge clk); #1;
    checkEq("irq_rx_clear", {31'd0, irq}, 32'd0);
    busWrite(32'hC, 32'h0);
`endif

    // Reset mid-operation with a bus write in the reset cycle
    busWrite(32'h0, 32'hE0);
    busWrite(32'h0, 32'hE1);
    rxPushWord(32'hE2);
    busRead(32'h8, rd);
    Reset = 1; CS = 1; WE = 1; ADDR = 32'h0; wdata = 32'h55;
    @(posedge clk); #1;
    Reset = 0; CS = 0; WE = 0;
    checkEq("midreset_rdata", Data_BUS_READ, 32'h0);
    checkEq("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
    busRead(32'h8, rd);
    checkEq("midreset_status", rd, 32'h0000_000A);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
